ahb3lite_mem_slave: RTL and testbench
=====================================

Name: ahb3lite_mem_slave

Overview:
- AHB-Lite write/read responder: single-port word memory at the far end of the bus driven by the CPU/DMA burst master.
- Accepts NONSEQ/SEQ transfers, inserts a programmable number of wait states, and returns two-cycle ERROR responses for out-of-region or non-WORD accesses.
- Exposes write statistics so the verifier can check burst length, last address and last data against the master's programmed values.

Parameters:
- ADDR_W, 6: memory index width; depth = 2**ADDR_W 32-bit words; index = HADDR[ADDR_W-1:0] (word addressing, no byte offset).
- REGION, 26'h0: required value of HADDR[31:ADDR_W]; any mismatch gives ERROR.
- MAX_WAIT, 7: upper clamp on the wait-state count.

Ports:
- HCLK  in  1  bus clock; the only clock.
- HRESET  in  1  asynchronous, active-high reset.
- HSEL  in  1  slave select.
- HADDR  in  32  address.
- HWRITE  in  1  WRITE=1 / READ=0.
- HSIZE  in  3  transfer size; only WORD is legal.
- HBURST  in  HBURST_Type  burst type; informational, counted only.
- HTRANS  in  HTRANS_state  transfer type: IDLE/BUSY/NONSEQ/SEQ.
- HWDATA  in  32  write data, valid in the data phase.
- HREADY  in  1  bus-level ready (previous transfer complete).
- HRDATA  out  32  read data.
- HREADYOUT  out  1  this slave's ready.
- HRESP  out  HRESP_state  OKAY/ERROR.
- i_wait_n  in  3  wait states per transfer, sampled at the address phase and clamped to MAX_WAIT.
- o_wr_count  out  6  completed OKAY writes since the last NONSEQ write.
- o_last_addr  out  32  HADDR of the last completed write.
- o_last_data  out  32  HWDATA of the last completed write.
- o_err_count  out  8  ERROR responses issued; saturates at 255.

Behaviour:
- Reset (asynchronous, active-high): state=S_IDLE, HREADYOUT=1, HRESP=OKAY, HRDATA=0, all o_* outputs = 0, pending-transfer registers cleared. Memory contents are not reset.
- Acceptance: accept = HSEL & HREADY & (HTRANS==NONSEQ | HTRANS==SEQ). On accept, latch address, direction, index, wait count and error flag. error = (HADDR[31:ADDR_W] != REGION) | (HSIZE != WORD).
- IDLE, BUSY and unselected transfers produce no memory access and get a zero-wait OKAY response. A BUSY cycle does not advance o_wr_count.
- States:
  - S_IDLE: HREADYOUT=1, HRESP=OKAY.
    - accept & error -> S_ERR1.
    - accept & wait>0 -> S_WAIT with the counter loaded to wait-1.
    - accept & wait==0 -> S_DATA.
  - S_WAIT: HREADYOUT=0, HRESP=OKAY. Counter decrements each cycle; at 0 -> S_DATA.
  - S_DATA: HREADYOUT=1, HRESP=OKAY; this is the completion cycle.
    - Write: mem[idx] <= HWDATA at the clock edge; update o_last_addr/o_last_data; o_wr_count increments, or is set to 1 if the latched HTRANS was NONSEQ.
    - Read: HRDATA is driven from the register loaded at accept.
    - A new address phase may be accepted in the same cycle (pipelined); next state follows the S_IDLE accept rules, otherwise -> S_IDLE.
  - S_ERR1: HREADYOUT=0, HRESP=ERROR -> S_ERR2.
  - S_ERR2: HREADYOUT=1, HRESP=ERROR; o_err_count++. Any transfer presented this cycle is accepted as in S_IDLE, so a master that does not cancel still gets a response. No memory write on error.
- Read latency: zero-wait read data is visible one cycle after accept. Read data register loads mem[idx] on accept.
- Read-after-write hazard: if accept is a read of the index being written in the same S_DATA cycle, HRDATA takes HWDATA (forwarding).
- Width and index rules: o_wr_count wraps modulo 64; o_err_count saturates at 255; index wraps naturally within ADDR_W bits, so decrementing addresses at index 0 go to 2**ADDR_W-1.
- HSEL deasserted during S_WAIT does not abort; an already-accepted transfer always completes.
- Reset asserted mid-transfer: return to S_IDLE immediately; any write not yet completed is dropped.

Decomposition:
- Reuse from ahb3lite_pkg: HTRANS_state, HBURST_Type, HRESP_state, WORD, WRITE/READ.
- Add to ahb3lite_pkg: a slave_state enum {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2}.
- One sub-module, ahb3lite_word_ram: 2**ADDR_W x 32, one synchronous write port, one synchronous read port, with the write-forward mux kept inside the slave.

Test Plan:
- Reset then i_wait_n=0; SINGLE NONSEQ write HADDR=0x5, HWDATA=0xA5A5_0001; then read 0x5 -> HRDATA=0xA5A5_0001 one cycle after the read is accepted; o_wr_count=1, o_last_addr=0x5.
- INCR4 write, addresses 0x10,0x0F,0x0E,0x0D, data 0x100..0x103, i_wait_n=2 -> each beat has HREADYOUT low for exactly 2 cycles; memory holds 0x100..0x103 at 0x10..0x0D; o_wr_count=4.
- INCR8 with BUSY cycles inserted between beats -> OKAY zero-wait on BUSY cycles, no extra memory writes, o_wr_count=8.
- Write HADDR=0x0400_0003 (out of region) -> cycle 1: HREADYOUT=0, HRESP=ERROR; cycle 2: HREADYOUT=1, HRESP=ERROR; memory unchanged; o_err_count=1. Repeat with HSIZE=HALFWORD -> same response, o_err_count=2.
- Write 0x3=0xDEAD immediately followed by a pipelined read of 0x3 -> HRDATA=0xDEAD via forwarding.
- Assert HRESET during S_WAIT of a write to 0x7 -> HREADYOUT=1, HRESP=OKAY, state S_IDLE within the same cycle; mem[0x7] unchanged; o_wr_count=0.

Source files
------------

// File: rtl/ahb3lite_pkg.sv
// Shared AHB-Lite encodings plus the memory slave's FSM state type.
package ahb3lite_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } HTRANS_state;

  typedef enum logic [2:0] {
    SINGLE = 3'b000,
    INCR   = 3'b001,
    WRAP4  = 3'b010,
    INCR4  = 3'b011,
    WRAP8  = 3'b100,
    INCR8  = 3'b101,
    WRAP16 = 3'b110,
    INCR16 = 3'b111
  } HBURST_Type;

  typedef enum logic {
    OKAY  = 1'b0,
    ERROR = 1'b1
  } HRESP_state;

  localparam logic [2:0] BYTE     = 3'b000;
  localparam logic [2:0] HALFWORD = 3'b001;
  localparam logic [2:0] WORD     = 3'b010;

  localparam logic WRITE = 1'b1;
  localparam logic READ  = 1'b0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DATA,
    S_ERR1,
    S_ERR2
  } slave_state;

  // Widened compare keeps the clamp meaningful for any limit value.
  function automatic logic [2:0] clamp_wait(input logic [2:0] req, input logic [2:0] lim);
    return ({1'b0, req} > {1'b0, lim}) ? lim : req;
  endfunction

endpackage

// File: rtl/ahb3lite_word_ram.sv
// Word-wide RAM with one synchronous write port and one registered read port.
module ahb3lite_word_ram #(
  parameter int ADDR_W = 6
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [31:0]       i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [31:0]       o_rdata
);

  logic [31:0] r_mem [2**ADDR_W];

  // NOTE: storage arrays carry no reset so they map onto RAM macros; only the read register resets.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // A same-edge write is not visible here; the slave forwards around it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)     o_rdata <= '0;
    else if (i_re) o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/ahb3lite_mem_slave.sv
// AHB-Lite word memory responder with programmable wait states, ERROR
// responses for illegal accesses, and write statistics for bus verification.
module ahb3lite_mem_slave
  import ahb3lite_pkg::*;
#(
  parameter int                 ADDR_W   = 6,
  parameter logic [31-ADDR_W:0] REGION   = '0,
  parameter int                 MAX_WAIT = 7
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  HBURST_Type  HBURST,
  input  HTRANS_state HTRANS,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output HRESP_state  HRESP,
  input  logic [2:0]  i_wait_n,
  output logic [5:0]  o_wr_count,
  output logic [31:0] o_last_addr,
  output logic [31:0] o_last_data,
  output logic [7:0]  o_err_count
);

  localparam logic [2:0] MAX_WAIT_C = 3'(MAX_WAIT);

  slave_state        r_state;
  slave_state        w_next;
  logic [2:0]        r_wait_cnt;
  logic [31:0]       r_addr;
  logic [ADDR_W-1:0] r_idx;
  logic              r_write;
  logic              r_nonseq;
  logic              r_fwd;
  logic [31:0]       r_fwd_data;

  logic              w_trans_ok;
  logic              w_ready_state;
  logic              w_accept;
  logic              w_error;
  logic [ADDR_W-1:0] w_idx;
  logic [2:0]        w_wait;
  logic              w_wr_done;
  logic              w_rd_accept;
  logic              w_fwd;
  logic [31:0]       w_ram_rdata;
  logic              w_unused_burst;

  // Burst type is informational only; the slave treats every beat alike.
  assign w_unused_burst = ^HBURST;

  assign w_trans_ok    = (HTRANS == NONSEQ) || (HTRANS == SEQ);
  assign w_ready_state = r_state inside {S_IDLE, S_DATA, S_ERR2};
  assign w_accept      = HSEL && HREADY && w_trans_ok && w_ready_state;
  assign w_error       = (HADDR[31:ADDR_W] != REGION) || (HSIZE != WORD);
  assign w_idx         = HADDR[ADDR_W-1:0];
  assign w_wait        = clamp_wait(i_wait_n, MAX_WAIT_C);
  assign w_wr_done     = (r_state == S_DATA) && r_write;
  assign w_rd_accept   = w_accept && !w_error && (HWRITE == READ);
  // A read accepted while the same word is being written must see the new data.
  assign w_fwd         = w_rd_accept && w_wr_done && (w_idx == r_idx);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE, S_DATA, S_ERR2: begin
        if (!w_accept)         w_next = S_IDLE;
        else if (w_error)      w_next = S_ERR1;
        else if (w_wait != '0) w_next = S_WAIT;
        else                   w_next = S_DATA;
      end
      S_WAIT:  if (r_wait_cnt == '0) w_next = S_DATA;
      S_ERR1:  w_next = S_ERR2;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = OKAY;
    unique case (r_state)
      S_WAIT:  HREADYOUT = 1'b0;
      S_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = ERROR;
      end
      S_ERR2:  HRESP = ERROR;
      default: ;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_wait_cnt <= '0;
      r_addr     <= '0;
      r_idx      <= '0;
      r_write    <= 1'b0;
      r_nonseq   <= 1'b0;
    end else if (w_accept) begin
      r_wait_cnt <= (w_wait != '0) ? w_wait - 3'd1 : '0;
      r_addr     <= HADDR;
      r_idx      <= w_idx;
      r_write    <= (HWRITE == WRITE);
      r_nonseq   <= (HTRANS == NONSEQ);
    end else if (r_state == S_WAIT && r_wait_cnt != '0) begin
      r_wait_cnt <= r_wait_cnt - 3'd1;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_fwd      <= 1'b0;
      r_fwd_data <= '0;
    end else if (w_rd_accept) begin
      r_fwd      <= w_fwd;
      r_fwd_data <= HWDATA;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      o_wr_count  <= '0;
      o_last_addr <= '0;
      o_last_data <= '0;
      o_err_count <= '0;
    end else begin
      if (w_wr_done) begin
        o_last_addr <= r_addr;
        o_last_data <= HWDATA;
        o_wr_count  <= r_nonseq ? 6'd1 : o_wr_count + 6'd1;
      end
      if (r_state == S_ERR2 && o_err_count != 8'hFF) o_err_count <= o_err_count + 8'd1;
    end
  end

  ahb3lite_word_ram #(.ADDR_W(ADDR_W)) u_ram (
    .i_clk   (HCLK),
    .i_rst   (HRESET),
    .i_we    (w_wr_done),
    .i_waddr (r_idx),
    .i_wdata (HWDATA),
    .i_re    (w_rd_accept),
    .i_raddr (w_idx),
    .o_rdata (w_ram_rdata)
  );

  assign HRDATA = r_fwd ? r_fwd_data : w_ram_rdata;

endmodule

// File: tb/tb_ahb3lite_mem_slave.sv
// Directed bench for ahb3lite_mem_slave: single-slave bus with HREADY tied
// to HREADYOUT, expected values worked out by hand per transfer.
module tb_ahb3lite_mem_slave;
  import ahb3lite_pkg::*;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        HSEL;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  HBURST_Type  HBURST;
  HTRANS_state HTRANS;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  HRESP_state  HRESP;
  logic [2:0]  i_wait_n;
  logic [5:0]  o_wr_count;
  logic [31:0] o_last_addr;
  logic [31:0] o_last_data;
  logic [7:0]  o_err_count;

  int n_checks = 0;
  int n_fail   = 0;

  int          n_low;
  logic [31:0] rd;
  HRESP_state  resp_end;
  HRESP_state  resp_low;

  always #5 HCLK = ~HCLK;
  assign HREADY = HREADYOUT;

  ahb3lite_mem_slave dut (
    .HCLK        (HCLK),
    .HRESET      (HRESET),
    .HSEL        (HSEL),
    .HADDR       (HADDR),
    .HWRITE      (HWRITE),
    .HSIZE       (HSIZE),
    .HBURST      (HBURST),
    .HTRANS      (HTRANS),
    .HWDATA      (HWDATA),
    .HREADY      (HREADY),
    .HRDATA      (HRDATA),
    .HREADYOUT   (HREADYOUT),
    .HRESP       (HRESP),
    .i_wait_n    (i_wait_n),
    .o_wr_count  (o_wr_count),
    .o_last_addr (o_last_addr),
    .o_last_data (o_last_data),
    .o_err_count (o_err_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // One non-pipelined transfer; called just after a posedge with the slave ready.
  // 'gap' is the HTRANS shown during the data phase (IDLE or BUSY).
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                      input HTRANS_state tr, input logic [2:0] size, input HTRANS_state gap,
                      output int lows, output logic [31:0] rdata,
                      output HRESP_state r_end, output HRESP_state r_low);
    bit seen_ready;
    HSEL = 1'b1; HADDR = addr; HWRITE = wr; HTRANS = tr; HSIZE = size;
    @(posedge HCLK); #1;
    HTRANS = gap;
    HSEL   = (gap == BUSY);
    HWDATA = wr ? data : 32'h0;
    lows = 0; r_low = OKAY; seen_ready = 1'b0;
    for (int i = 0; i < 32; i++) begin
      @(negedge HCLK);
      if (HREADYOUT) begin
        seen_ready = 1'b1;
        break;
      end
      if (lows == 0) r_low = HRESP;
      lows++;
    end
    if (!seen_ready) check("xfer_timeout", 32'(HREADYOUT), 32'h1);
    rdata = HRDATA;
    r_end = HRESP;
    @(posedge HCLK); #1;
  endtask

  initial begin
    HRESET = 1'b1; HSEL = 1'b0; HADDR = '0; HWRITE = READ; HSIZE = WORD;
    HBURST = SINGLE; HTRANS = IDLE; HWDATA = '0; i_wait_n = 3'd0;
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    check("rst_hreadyout", 32'(HREADYOUT), 32'h1);
    check("rst_hresp",     32'(HRESP),     32'(OKAY));
    check("rst_hrdata",    HRDATA,         32'h0);
    check("rst_wr_count",  32'(o_wr_count), 32'h0);
    check("rst_last_addr", o_last_addr,    32'h0);
    check("rst_last_data", o_last_data,    32'h0);
    check("rst_err_count", 32'(o_err_count), 32'h0);
    @(posedge HCLK); #1;
    HRESET = 1'b0;

    // Single write then read-back, zero wait.
    xfer(WRITE, 32'h5, 32'hA5A5_0001, NONSEQ, WORD, IDLE, n_low, rd, resp_end, resp_low);
    check("single_wr_lows", 32'(n_low), 32'd0);
    xfer(READ, 32'h5, 32'h0, NONSEQ, WORD, IDLE, n_low, rd, resp_end, resp_low);
    check("single_rd_data", rd, 32'hA5A5_0001);
    check("single_wr_count", 32'(o_wr_count), 32'd1);
    check("single_last_addr", o_last_addr, 32'h5);
    check("single_last_data", o_last_data, 32'hA5A5_0001);

    // INCR4 with two wait states, decrementing addresses.
    i_wait_n = 3'd2; HBURST = INCR4;
    for (int i = 0; i < 4; i++) begin
      xfer(WRITE, 32'h10 - 32'(i), 32'h100 + 32'(i), (i == 0) ? NONSEQ : SEQ, WORD,
           (i == 3) ? IDLE : BUSY, n_low, rd, resp_end, resp_low);
      check($sformatf("incr4_lows%0d", i), 32'(n_low), 32'd2);
    end
    check("incr4_wr_count", 32'(o_wr_count), 32'd4);
    i_wait_n = 3'd0; HBURST = SINGLE;
    for (int i = 0; i < 4; i++) begin
      xfer(READ, 32'h10 - 32'(i), 32'h0, NONSEQ, WORD, IDLE, n_low, rd, resp_end, resp_low);
      check($sformatf("incr4_mem%0d", i), rd, 32'h100 + 32'(i));
    end

    // INCR8 with one wait state and an explicit BUSY cycle between beats.
    i_wait_n = 3'd1; HBURST = INCR8;
    for (int i = 0; i < 8; i++) begin
      xfer(WRITE, 32'(i), 32'h200 + 32'(i), (i == 0) ? NONSEQ : SEQ, WORD,
           (i == 7) ? IDLE : BUSY, n_low, rd, resp_end, resp_low);
      if (i < 7) begin
        HSEL = 1'b1; HTRANS = BUSY; HADDR = 32'(i + 1); HWRITE = WRITE;
        @(negedge HCLK);
        check($sformatf("busy_ready%0d", i), 32'(HREADYOUT), 32'h1);
        check($sformatf("busy_resp%0d", i), 32'(HRESP), 32'(OKAY));
        @(posedge HCLK); #1;
      end
    end
    HSEL = 1'b0; HTRANS = IDLE; HBURST = SINGLE;
    check("incr8_wr_count", 32'(o_wr_count), 32'd8);
    check("incr8_last_addr", o_last_addr, 32'h7);
    check("incr8_last_data", o_last_data, 32'h207);

    // Out-of-region and HALFWORD writes get the two-cycle ERROR response.
    i_wait_n = 3'd0;
    xfer(WRITE, 32'h0400_0003, 32'h0BAD_0BAD, NONSEQ, WORD, IDLE, n_low, rd, resp_end, resp_low);
    check("err_region_lows", 32'(n_low), 32'd1);
    check("err_region_resp1", 32'(resp_low), 32'(ERROR));
    check("err_region_resp2", 32'(resp_end), 32'(ERROR));
    check("err_region_count", 32'(o_err_count), 32'd1);
    i_wait_n = 3'd2;
    xfer(WRITE, 32'h3, 32'h0BAD_0BAD, NONSEQ, HALFWORD, IDLE, n_low, rd, resp_end, resp_low);
    check("err_size_lows", 32'(n_low), 32'd1);
    check("err_size_resp1", 32'(resp_low), 32'(ERROR));
    check("err_size_resp2", 32'(resp_end), 32'(ERROR));
    check("err_size_count", 32'(o_err_count), 32'd2);
    check("err_wr_count", 32'(o_wr_count), 32'd8);
    i_wait_n = 3'd0;
    xfer(READ, 32'h3, 32'h0, NONSEQ, WORD, IDLE, n_low, rd, resp_end, resp_low);
    check("err_mem_unchanged", rd, 32'h203);

    // Write 0x3 with a pipelined read of 0x3 in its data phase.
    HSEL = 1'b1; HADDR = 32'h3; HWRITE = WRITE; HTRANS = NONSEQ; HSIZE = WORD;
    @(posedge HCLK); #1;
    HWDATA = 32'hDEAD; HWRITE = READ; HTRANS = NONSEQ; HADDR = 32'h3;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = IDLE; HWDATA = '0;
    @(negedge HCLK);
    check("fwd_ready", 32'(HREADYOUT), 32'h1);
    check("fwd_hrdata", HRDATA, 32'hDEAD);
    check("fwd_last_data", o_last_data, 32'hDEAD);
    @(posedge HCLK); #1;

    // Reset asserted while a write to 0x7 is in its wait states.
    i_wait_n = 3'd3;
    HSEL = 1'b1; HADDR = 32'h7; HWRITE = WRITE; HTRANS = NONSEQ; HSIZE = WORD;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = IDLE; HWDATA = 32'h0BAD_0007;
    @(negedge HCLK);
    check("rstw_waiting", 32'(HREADYOUT), 32'h0);
    #1 HRESET = 1'b1;
    #1;
    check("rstw_hreadyout", 32'(HREADYOUT), 32'h1);
    check("rstw_hresp", 32'(HRESP), 32'(OKAY));
    check("rstw_state", 32'(dut.r_state), 32'(S_IDLE));
    check("rstw_wr_count", 32'(o_wr_count), 32'h0);
    check("rstw_hrdata", HRDATA, 32'h0);
    @(posedge HCLK); #1;
    HRESET = 1'b0; i_wait_n = 3'd0;
    xfer(READ, 32'h7, 32'h0, NONSEQ, WORD, IDLE, n_low, rd, resp_end, resp_low);
    check("rstw_mem_unchanged", rd, 32'h207);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
